// File: rtl/instr_loader_if.sv
// Handshake and write-port bundle between the byte-stream source, the loader and instruction memory.
interface instr_loader_if;
    logic        start_i;
    logic        byte_valid_i;
    logic [7:0]  byte_data_i;
    logic        byte_ready_o;
    logic        imem_wEN_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_o;
    logic        core_nRST_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    modport slave (
        input  start_i, byte_valid_i, byte_data_i,
        output byte_ready_o, imem_wEN_o, imem_addr_o, imem_data_o,
        output core_nRST_o, busy_o, done_o, err_o
    );

    modport master (
        output start_i, byte_valid_i, byte_data_i,
        input  byte_ready_o, imem_wEN_o, imem_addr_o, imem_data_o,
        input  core_nRST_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/instr_loader.sv
// Serial instruction loader: header word count, little-endian payload words into imem, core held in reset until done.
// Optional trailing XOR checksum byte enabled by defining LOADER_CKSUM_EN.
module instr_loader #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input logic           CLK,
    input logic           nRST,
    instr_loader_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
`ifdef LOADER_CKSUM_EN
        CKSUM,
`endif
        DONE,
        ERR
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  byte_cnt;
    logic [7:0]  n_lo;
    logic [15:0] n_words;
    logic [15:0] idx;
    logic [23:0] word_buf;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] data;
    logic        ready;
    logic        busy;
    logic        accept;
    logic        start_ok;
    logic        last_word;
    logic        hdr_bad;
    logic [15:0] hdr_n;
`ifdef LOADER_CKSUM_EN
    logic [7:0]  cksum;
`endif

    assign accept    = bus.byte_valid_i && ready;
    assign start_ok  = bus.start_i && (state == IDLE || state == DONE || state == ERR);
    assign hdr_n     = {bus.byte_data_i, n_lo};
    assign hdr_bad   = (hdr_n == 16'd0) || ({16'd0, hdr_n} > 32'(DEPTH_WORDS));
    assign last_word = (idx == (n_words - 16'd1));

    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        case (state)
            HDR:   begin ready = 1'b1; busy = 1'b1; end
            DATA:  begin ready = !wen; busy = 1'b1; end
`ifdef LOADER_CKSUM_EN
            CKSUM: begin ready = 1'b1; busy = 1'b1; end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERR: if (bus.start_i) state_nxt = HDR;
            HDR: if (accept && byte_cnt == 2'd1) state_nxt = hdr_bad ? ERR : DATA;
            // The strobe cycle doubles as the decision point for leaving DATA.
            DATA: if (wen && last_word) begin
`ifdef LOADER_CKSUM_EN
                state_nxt = CKSUM;
`else
                state_nxt = DONE;
`endif
            end
`ifdef LOADER_CKSUM_EN
            CKSUM: if (accept) state_nxt = (bus.byte_data_i == cksum) ? DONE : ERR;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            byte_cnt <= 2'd0;
            n_lo     <= 8'd0;
            n_words  <= 16'd0;
            idx      <= 16'd0;
            word_buf <= 24'd0;
            wen      <= 1'b0;
            addr     <= 32'd0;
            data     <= 32'd0;
`ifdef LOADER_CKSUM_EN
            cksum    <= 8'd0;
`endif
        end else begin
            wen <= 1'b0;
            if (start_ok) begin
                byte_cnt <= 2'd0;
                idx      <= 16'd0;
`ifdef LOADER_CKSUM_EN
                cksum    <= 8'd0;
`endif
            end
            if (state == HDR && accept) begin
`ifdef LOADER_CKSUM_EN
                cksum <= cksum ^ bus.byte_data_i;
`endif
                if (byte_cnt == 2'd0) begin
                    n_lo     <= bus.byte_data_i;
                    byte_cnt <= 2'd1;
                end else begin
                    n_words  <= hdr_n;
                    byte_cnt <= 2'd0;
                end
            end
            if (state == DATA) begin
                if (wen) begin
                    idx <= idx + 16'd1;
                end else if (accept) begin
`ifdef LOADER_CKSUM_EN
                    cksum <= cksum ^ bus.byte_data_i;
`endif
                    byte_cnt <= byte_cnt + 2'd1;
                    case (byte_cnt)
                        2'd0: word_buf[7:0]   <= bus.byte_data_i;
                        2'd1: word_buf[15:8]  <= bus.byte_data_i;
                        2'd2: word_buf[23:16] <= bus.byte_data_i;
                        default: begin
                            data <= {bus.byte_data_i, word_buf};
                            addr <= BASE_ADDR + {14'd0, idx, 2'b00};
                            wen  <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.byte_ready_o = ready;
    assign bus.busy_o       = busy;
    assign bus.imem_wEN_o   = wen;
    assign bus.imem_addr_o  = addr;
    assign bus.imem_data_o  = data;
    assign bus.done_o       = (state == DONE);
    assign bus.err_o        = (state == ERR);
    assign bus.core_nRST_o  = (state == DONE);
endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: Instr_Loader

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all state SHALL change on the rising edge of CLK.
REQ-002 Parameter DEPTH_WORDS, default 256, SHALL set the maximum number of words loadable into instruction memory.
REQ-003 Parameter BASE_ADDR, default 32'h0, SHALL set the byte address of the first loaded word.
REQ-004 CLK  input  1  system clock.
REQ-005 nRST  input  1  asynchronous active-low reset.
REQ-006 start_i  input  1  requests a new load; sampled only in IDLE, DONE and ERR.
REQ-007 byte_valid_i  input  1  source has a byte on byte_data_i.
REQ-008 byte_data_i  input  8  serial stream byte.
REQ-009 byte_ready_o  output  1  loader can accept a byte this cycle.
REQ-010 imem_wEN_o  output  1  one-cycle instruction-memory write strobe.
REQ-011 imem_addr_o  output  32  write byte address.
REQ-012 imem_data_o  output  32  write word.
REQ-013 core_nRST_o  output  1  active-low reset to the pipeline core; low holds the core.
REQ-014 busy_o  output  1  high in HDR, DATA and CKSUM.
REQ-015 done_o  output  1  high in DONE.
REQ-016 err_o  output  1  high in ERR.

Function
REQ-017 A byte SHALL be accepted on a rising edge only when byte_valid_i and byte_ready_o are both high.
REQ-018 The FSM SHALL have the states IDLE, HDR, DATA, CKSUM, DONE and ERR.
REQ-019 IDLE/DONE/ERR + start_i -> HDR on the next edge; clear the word index, the byte counter and the checksum.
REQ-020 HDR: accept 2 bytes, little-endian, forming a 16-bit word count N; after the 2nd byte, N==0 or N>DEPTH_WORDS -> ERR, otherwise -> DATA.
REQ-021 DATA: assemble 4 bytes little-endian (first byte = bits 7:0) into a word.
REQ-022 The cycle after the 4th byte is accepted, imem_wEN_o SHALL be high for exactly one cycle, with imem_addr_o = BASE_ADDR + 4*index and imem_data_o = the assembled word.
REQ-023 byte_ready_o SHALL be low in the write-strobe cycle, so the worst-case throughput is 4 bytes per 5 cycles.
REQ-024 The index SHALL increment after each strobe; after word N-1 is strobed, the FSM SHALL go to CKSUM (macro defined) or DONE (macro undefined).
REQ-025 byte_ready_o SHALL be high in HDR, DATA (except the strobe cycle) and CKSUM, and low in IDLE, DONE and ERR.
REQ-026 core_nRST_o SHALL be high only in DONE and low in all other states.
REQ-027 A new start_i in DONE SHALL drop core_nRST_o on the next edge.
REQ-028 start_i SHALL be ignored in HDR, DATA and CKSUM.
REQ-029 imem_addr_o and imem_data_o SHALL hold their last values when imem_wEN_o is low.
REQ-030 Address arithmetic SHALL be 32-bit modulo 2^32.

Reset
REQ-031 Asserting nRST SHALL immediately force:
- state = IDLE;
- byte_ready_o = imem_wEN_o = busy_o = done_o = err_o = 0;
- core_nRST_o = 0;
- imem_addr_o = imem_data_o = 0;
- all counters and the checksum = 0.
REQ-032 Reset during any state, including mid-word, SHALL discard partial data; no imem_wEN_o pulse SHALL occur after reset assertion.

Configuration
REQ-033 Macro LOADER_CKSUM_EN defined: after the last word, CKSUM accepts 1 byte; it is compared with the XOR of all header and payload bytes; match -> DONE, mismatch -> ERR.
REQ-034 Macro LOADER_CKSUM_EN undefined: the CKSUM state and checksum logic SHALL be absent and the last word -> DONE.

Verification
REQ-035 Scenario: reset, start_i, bytes 01 00 13 05 A0 00 -> one strobe with addr 0x0 and data 0x00A00513; done_o=1; core_nRST_o=1.
REQ-036 Scenario: header 00 00, then header 01 01 with DEPTH_WORDS=256 -> err_o=1, no strobe, core_nRST_o=0.
REQ-037 Scenario: N=3 streamed with byte_valid_i held high -> strobes at addresses 0x0, 0x4 and 0x8; byte_ready_o low exactly in each strobe cycle.
REQ-038 Scenario: nRST asserted after 2 payload bytes, then a full N=1 load -> only the second load's word is written.
REQ-039 Scenario (LOADER_CKSUM_EN): payload with a correct XOR byte -> DONE; same payload with the XOR byte bit-flipped -> ERR.
REQ-040 Scenario: start_i pulsed in DATA -> no effect; start_i in DONE -> core_nRST_o=0 on the next cycle and busy_o=1.
